muldiv_hilo_ex_stage: RTL and testbench
=======================================

// Module: muldiv_hilo_EX_stage
// PURPOSE
//  EX-stage multiply/divide unit with architectural HI/LO registers. Consumes the ID/EX
//  stage-register outputs (op select, rs/rt operand values) and executes MULT/MULTU/DIV/DIVU
//  iteratively, one bit per clock. Executes MFHI/MFLO/MTHI/MTLO in a single cycle.
//  Raises out_stall so the hazard logic holds IF/ID and ID/EX while a mul/div op is in flight.
// PARAMETERS
//  DATA_W   32   operand/HI/LO width; iteration count = DATA_W; counter width = $clog2(DATA_W)
// PORTS
//  clock            in   1       rising-edge clock
//  reset_n          in   1       asynchronous, active-low reset
//  in_valid         in   1       ID/EX holds a valid instruction this cycle
//  in_op            in   4       0 NOP,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MFHI,6 MFLO,7 MTHI,8 MTLO; 9-15 = NOP
//  in_rs_val        in   DATA_W  rs operand (dividend / multiplicand / MTHI,MTLO source)
//  in_rt_val        in   DATA_W  rt operand (divisor / multiplier)
//  in_flush         in   1       kill in-flight op (exception / branch squash)
//  out_stall        out  1       comb: in_valid & op in 1..8 & out_busy
//  out_busy         out  1       comb decode: state != IDLE
//  out_result       out  DATA_W  comb: HI for MFHI, LO for MFLO, else 0
//  out_done         out  1       registered 1-cycle pulse: HI/LO just written by MULT*/DIV*
//  out_div_zero     out  1       registered 1-cycle pulse with out_done: DIV/DIVU had rt==0
//  out_hi, out_lo   out  DATA_W  architectural HI/LO register contents
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, HI=0, LO=0, counter=0, all internal regs 0,
//   out_done=0, out_div_zero=0. Release is synchronous to next clock edge.
//  States: IDLE -> ITER (DATA_W edges) -> FIX (1 edge) -> IDLE.
//  Accept: at edge k, when state==IDLE & in_valid & ~in_flush & op in {1..4}. Operands latched;
//   signed ops latch |rs|,|rt| and sign flags; cnt=0; state->ITER.
//  ITER: multiply = shift-add on 2*DATA_W accumulator; divide = restoring shift-subtract.
//   One iteration per edge, edges k+1..k+DATA_W; at cnt==DATA_W-1 state->FIX.
//  FIX (edge k+DATA_W+1, i.e. k+33 at default): apply signs, write HI/LO, state->IDLE,
//   out_done=1 for that following cycle. Results visible on out_hi/out_lo after edge k+33.
//  Multiply: {HI,LO} = 64-bit product; MULT signed, MULTU unsigned.
//  Divide: LO=quotient, HI=remainder. Signed: quotient negative iff sign(rs)^sign(rt);
//   remainder takes sign of rs. 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
//  Divide by zero (rt==0 at accept): no ITER; at edge k HI<=rs, LO<=32'hFFFFFFFF,
//   state stays IDLE, out_done & out_div_zero pulse next cycle.
//  MTHI/MTLO: IDLE & in_valid & ~in_flush -> HI/LO <= rs at that edge. No out_done pulse.
//  MFHI/MFLO: out_result combinational from current HI/LO; valid only when not busy.
//  While busy: any op 1..8 with in_valid asserts out_stall and is NOT executed; it is
//   re-presented by the held ID/EX register and accepted in the first IDLE cycle.
//   Op 0/9-15 while busy: no stall, ignored.
//  in_flush: in ITER/FIX -> state->IDLE at next edge, HI/LO unchanged, no out_done.
//   In IDLE, in_flush & in_valid same cycle -> flush wins, nothing accepted or written.
//  FIX and a new valid op in the same cycle: op stalls (busy), accepted next cycle.
//  Mid-operation reset: HI/LO cleared, state IDLE, no pulse.
// TESTING
//  MULT rs=0xFFFFFFFE(-2), rt=3 -> after 33 edges HI=0xFFFFFFFF, LO=0xFFFFFFFA, out_done 1 cycle.
//  MULTU rs=rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; out_busy high exactly 33 cycles.
//  DIV rs=-7, rt=2 -> LO=0xFFFFFFFD(-3), HI=0xFFFFFFFF(-1); DIVU 7/2 -> LO=3, HI=1.
//  DIV rs=0x80000000, rt=0xFFFFFFFF -> LO=0x80000000, HI=0; DIVU rs=5, rt=0 -> HI=5,
//   LO=0xFFFFFFFF, out_div_zero pulse at edge+1.
//  MFLO presented 1 cycle after MULT accept -> out_stall held until IDLE, then out_result=LO new.
//  in_flush at ITER cnt=10 -> IDLE next edge, HI/LO retain prior MTHI/MTLO values, no out_done.

Source files
------------

// File: rtl/muldiv_hilo_ex_stage.sv
// EX-stage iterative multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU take DATA_W iteration cycles plus one sign-fix cycle; HI/LO moves are single-cycle.
module muldiv_hilo_ex_stage #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [3:0]        in_op,
  input  logic [DATA_W-1:0] in_rs_val,
  input  logic [DATA_W-1:0] in_rt_val,
  input  logic              in_flush,
  output logic              out_stall,
  output logic              out_busy,
  output logic [DATA_W-1:0] out_result,
  output logic              out_done,
  output logic              out_div_zero,
  output logic [DATA_W-1:0] out_hi,
  output logic [DATA_W-1:0] out_lo
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned ACC_W = 2 * DATA_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  logic [1:0]        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [ACC_W-1:0]  acc, acc_nxt;
  logic [DATA_W-1:0] opnd, opnd_nxt;
  logic              is_div, is_div_nxt;
  logic              neg_lo, neg_lo_nxt;
  logic              neg_hi, neg_hi_nxt;
  logic [DATA_W-1:0] hi_q, hi_nxt;
  logic [DATA_W-1:0] lo_q, lo_nxt;
  logic              done_q, done_nxt;
  logic              dz_q, dz_nxt;

  // Operand decode at accept: signed ops work on magnitudes and remember the signs
  logic              op_md, op_div, op_signed, rs_neg, rt_neg;
  logic [DATA_W-1:0] abs_rs, abs_rt;

  assign op_md     = (in_op >= OP_MULT) && (in_op <= OP_DIVU);
  assign op_div    = (in_op == OP_DIV) || (in_op == OP_DIVU);
  assign op_signed = (in_op == OP_MULT) || (in_op == OP_DIV);
  assign rs_neg    = op_signed && in_rs_val[DATA_W-1];
  assign rt_neg    = op_signed && in_rt_val[DATA_W-1];
  assign abs_rs    = rs_neg ? (DATA_W'(0) - in_rs_val) : in_rs_val;
  assign abs_rt    = rt_neg ? (DATA_W'(0) - in_rt_val) : in_rt_val;

  // One shift-add step: acc = {partial product, remaining multiplier bits}
  logic [DATA_W:0]   mul_sum;
  logic [ACC_W-1:0]  mul_step;

  assign mul_sum  = {1'b0, acc[ACC_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : (DATA_W+1)'(0));
  assign mul_step = {mul_sum, acc[DATA_W-1:1]};

  // One restoring-division step: acc = {partial remainder, dividend/quotient bits}
  logic [DATA_W:0]   rem_sh, rem_diff;
  logic [ACC_W-1:0]  div_step;

  assign rem_sh   = {acc[ACC_W-1:DATA_W], acc[DATA_W-1]};
  assign rem_diff = rem_sh - {1'b0, opnd};
  assign div_step = rem_diff[DATA_W] ? {rem_sh[DATA_W-1:0], acc[DATA_W-2:0], 1'b0}
                                     : {rem_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};

  // Sign restoration applied in FIX
  logic [ACC_W-1:0]  prod_fix;
  logic [DATA_W-1:0] quo_fix, rem_fix;

  assign prod_fix = neg_lo ? (ACC_W'(0) - acc) : acc;
  assign quo_fix  = neg_lo ? (DATA_W'(0) - acc[DATA_W-1:0]) : acc[DATA_W-1:0];
  assign rem_fix  = neg_hi ? (DATA_W'(0) - acc[ACC_W-1:DATA_W]) : acc[ACC_W-1:DATA_W];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      acc    <= acc_nxt;
      opnd   <= opnd_nxt;
      is_div <= is_div_nxt;
      neg_lo <= neg_lo_nxt;
      neg_hi <= neg_hi_nxt;
      hi_q   <= hi_nxt;
      lo_q   <= lo_nxt;
      done_q <= done_nxt;
      dz_q   <= dz_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    acc_nxt    = acc;
    opnd_nxt   = opnd;
    is_div_nxt = is_div;
    neg_lo_nxt = neg_lo;
    neg_hi_nxt = neg_hi;
    hi_nxt     = hi_q;
    lo_nxt     = lo_q;
    done_nxt   = 1'b0;
    dz_nxt     = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid && !in_flush) begin
          if (op_md) begin
            if (op_div && (in_rt_val == '0)) begin
              hi_nxt   = in_rs_val;
              lo_nxt   = '1;
              done_nxt = 1'b1;
              dz_nxt   = 1'b1;
            end else begin
              state_nxt  = S_ITER;
              cnt_nxt    = '0;
              acc_nxt    = {DATA_W'(0), abs_rs};
              opnd_nxt   = abs_rt;
              is_div_nxt = op_div;
              neg_lo_nxt = rs_neg ^ rt_neg;
              neg_hi_nxt = rs_neg;
            end
          end else if (in_op == OP_MTHI) begin
            hi_nxt = in_rs_val;
          end else if (in_op == OP_MTLO) begin
            lo_nxt = in_rs_val;
          end
        end
      end
      S_ITER: begin
        if (in_flush) begin
          state_nxt = S_IDLE;
        end else begin
          acc_nxt = is_div ? div_step : mul_step;
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt == CNT_W'(DATA_W - 1)) state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        state_nxt = S_IDLE;
        if (!in_flush) begin
          if (is_div) begin
            hi_nxt = rem_fix;
            lo_nxt = quo_fix;
          end else begin
            hi_nxt = prod_fix[ACC_W-1:DATA_W];
            lo_nxt = prod_fix[DATA_W-1:0];
          end
          done_nxt = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign out_busy     = (state != S_IDLE);
  assign out_stall    = in_valid && (in_op >= OP_MULT) && (in_op <= OP_MTLO) && out_busy;
  assign out_result   = (in_op == OP_MFHI) ? hi_q :
                        (in_op == OP_MFLO) ? lo_q : '0;
  assign out_done     = done_q;
  assign out_div_zero = dz_q;
  assign out_hi       = hi_q;
  assign out_lo       = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_ex_stage.sv
// Self-checking bench for muldiv_hilo_ex_stage: directed corner cases plus random
// mul/div traffic compared against plain 64-bit arithmetic.
module tb_muldiv_hilo_ex_stage;

  localparam int unsigned DATA_W = 32;

  logic              clock;
  logic              reset_n;
  logic              in_valid;
  logic [3:0]        in_op;
  logic [DATA_W-1:0] in_rs_val;
  logic [DATA_W-1:0] in_rt_val;
  logic              in_flush;
  logic              out_stall;
  logic              out_busy;
  logic [DATA_W-1:0] out_result;
  logic              out_done;
  logic              out_div_zero;
  logic [DATA_W-1:0] out_hi;
  logic [DATA_W-1:0] out_lo;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  muldiv_hilo_ex_stage #(.DATA_W(DATA_W)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_op        (in_op),
    .in_rs_val    (in_rs_val),
    .in_rt_val    (in_rt_val),
    .in_flush     (in_flush),
    .out_stall    (out_stall),
    .out_busy     (out_busy),
    .out_result   (out_result),
    .out_done     (out_done),
    .out_div_zero (out_div_zero),
    .out_hi       (out_hi),
    .out_lo       (out_lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: {HI,LO} from ordinary arithmetic on 64-bit integers
  function automatic logic [63:0] ref_md(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [31:0]     q, r;
    sa = longint'($signed(rs));
    sb = longint'($signed(rt));
    ua = {32'd0, rs};
    ub = {32'd0, rt};
    q  = '0;
    r  = '0;
    case (op)
      4'd1: return 64'(sa * sb);
      4'd2: return ua * ub;
      4'd3: begin
        if (rt == 0) return {rs, 32'hFFFF_FFFF};
        q = 32'(sa / sb);
        r = 32'(sa % sb);
        return {r, q};
      end
      4'd4: begin
        if (rt == 0) return {rs, 32'hFFFF_FFFF};
        q = 32'(ua / ub);
        r = 32'(ua % ub);
        return {r, q};
      end
      default: return 64'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Presents one mul/div op for a single cycle, then waits (bounded) for out_done
  task automatic issue_md(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          output int busy_cycles, output bit got_done, output logic dz);
    in_valid  = 1'b1;
    in_op     = op;
    in_rs_val = rs;
    in_rt_val = rt;
    tick();
    in_valid    = 1'b0;
    in_op       = 4'd0;
    busy_cycles = 0;
    got_done    = 1'b0;
    dz          = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (out_done) begin
        got_done = 1'b1;
        dz       = out_div_zero;
        break;
      end
      if (out_busy) busy_cycles++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_op     = 4'd0;
    in_rs_val = '0;
    in_rt_val = '0;
    in_flush  = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({out_hi, out_lo} !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_hilo: got hi=%h lo=%h, want 0/0", out_hi, out_lo);
    end
    n_checks++;
    if ({out_busy, out_done, out_div_zero, out_stall} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got busy/done/dz/stall=%b, want 0000",
               {out_busy, out_done, out_div_zero, out_stall});
    end
    reset_n = 1'b1;
    tick();
    n_checks++;
    if (out_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_busy: got %b, want 0", out_busy);
    end
  endtask

  task automatic test_mult_directed();
    int   bc;
    bit   gd;
    logic dz;
    issue_md(4'd1, 32'hFFFF_FFFE, 32'd3, bc, gd, dz);
    n_checks++;
    if (!gd || out_hi !== 32'hFFFF_FFFF || out_lo !== 32'hFFFF_FFFA) begin
      n_fail++;
      $display("FAIL mult_neg2x3: done=%0d hi=%h lo=%h, want done=1 hi=ffffffff lo=fffffffa", gd, out_hi, out_lo);
    end
    n_checks++;
    if (bc != 33) begin
      n_fail++;
      $display("FAIL mult_latency: busy %0d cycles, want 33", bc);
    end
    tick();
    n_checks++;
    if (out_done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse_width: out_done=%b one cycle later, want 0", out_done);
    end
    issue_md(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, gd, dz);
    n_checks++;
    if (!gd || out_hi !== 32'hFFFF_FFFE || out_lo !== 32'h0000_0001 || bc != 33 || dz !== 1'b0) begin
      n_fail++;
      $display("FAIL multu_max: done=%0d busy=%0d dz=%b hi=%h lo=%h, want 1/33/0 fffffffe/00000001",
               gd, bc, dz, out_hi, out_lo);
    end
    m_hi = out_hi;
    m_lo = out_lo;
  endtask

  task automatic test_div_directed();
    int   bc;
    bit   gd;
    logic dz;
    issue_md(4'd3, 32'hFFFF_FFF9, 32'd2, bc, gd, dz);
    n_checks++;
    if (!gd || out_lo !== 32'hFFFF_FFFD || out_hi !== 32'hFFFF_FFFF || dz !== 1'b0) begin
      n_fail++;
      $display("FAIL div_neg7_2: done=%0d dz=%b hi=%h lo=%h, want hi=ffffffff lo=fffffffd", gd, dz, out_hi, out_lo);
    end
    issue_md(4'd4, 32'd7, 32'd2, bc, gd, dz);
    n_checks++;
    if (!gd || out_lo !== 32'd3 || out_hi !== 32'd1) begin
      n_fail++;
      $display("FAIL divu_7_2: done=%0d hi=%h lo=%h, want hi=1 lo=3", gd, out_hi, out_lo);
    end
    issue_md(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, bc, gd, dz);
    n_checks++;
    if (!gd || out_lo !== 32'h8000_0000 || out_hi !== 32'd0) begin
      n_fail++;
      $display("FAIL div_overflow: done=%0d hi=%h lo=%h, want hi=0 lo=80000000", gd, out_hi, out_lo);
    end
    issue_md(4'd4, 32'd5, 32'd0, bc, gd, dz);
    n_checks++;
    if (!gd || dz !== 1'b1 || out_hi !== 32'd5 || out_lo !== 32'hFFFF_FFFF || bc != 0) begin
      n_fail++;
      $display("FAIL divu_by_zero: done=%0d dz=%b busy=%0d hi=%h lo=%h, want 1/1/0 hi=5 lo=ffffffff",
               gd, dz, bc, out_hi, out_lo);
    end
    tick();
    n_checks++;
    if ({out_done, out_div_zero} !== 2'b00) begin
      n_fail++;
      $display("FAIL div_zero_pulse_width: done/dz=%b, want 00", {out_done, out_div_zero});
    end
    m_hi = out_hi;
    m_lo = out_lo;
  endtask

  task automatic test_move();
    logic [31:0] a, b;
    a = $urandom;
    b = $urandom;
    in_valid  = 1'b1;
    in_op     = 4'd7;
    in_rs_val = a;
    tick();
    in_op     = 4'd8;
    in_rs_val = b;
    tick();
    in_valid  = 1'b0;
    in_op     = 4'd0;
    m_hi = a;
    m_lo = b;
    #1;
    n_checks++;
    if (out_hi !== m_hi || out_lo !== m_lo || out_done !== 1'b0) begin
      n_fail++;
      $display("FAIL mthi_mtlo: hi=%h lo=%h done=%b, want %h %h 0", out_hi, out_lo, out_done, m_hi, m_lo);
    end
    in_op = 4'd5;
    #1;
    n_checks++;
    if (out_result !== m_hi) begin
      n_fail++;
      $display("FAIL mfhi: result=%h, want %h", out_result, m_hi);
    end
    in_op = 4'd6;
    #1;
    n_checks++;
    if (out_result !== m_lo) begin
      n_fail++;
      $display("FAIL mflo: result=%h, want %h", out_result, m_lo);
    end
    in_op = 4'd1;
    #1;
    n_checks++;
    if (out_result !== 32'd0) begin
      n_fail++;
      $display("FAIL result_other_op: result=%h, want 0", out_result);
    end
    in_op = 4'd0;
    tick();
  endtask

  task automatic test_stall_mflo();
    logic [31:0] rs, rt;
    logic [63:0] exp;
    int          sc;
    rs  = $urandom;
    rt  = $urandom;
    exp = ref_md(4'd1, rs, rt);
    in_valid  = 1'b1;
    in_op     = 4'd1;
    in_rs_val = rs;
    in_rt_val = rt;
    tick();
    in_op = 4'd6;
    #1;
    sc = 0;
    for (int i = 0; i < 64; i++) begin
      if (!out_stall) break;
      sc++;
      tick();
    end
    n_checks++;
    if (sc != 33) begin
      n_fail++;
      $display("FAIL mflo_stall_len: stalled %0d cycles, want 33", sc);
    end
    n_checks++;
    if (out_result !== exp[31:0] || out_done !== 1'b1) begin
      n_fail++;
      $display("FAIL mflo_after_mult: result=%h done=%b, want %h 1", out_result, out_done, exp[31:0]);
    end
    in_op = 4'd5;
    #1;
    n_checks++;
    if (out_result !== exp[63:32]) begin
      n_fail++;
      $display("FAIL mfhi_after_mult: result=%h, want %h", out_result, exp[63:32]);
    end
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    in_valid = 1'b0;
    in_op    = 4'd0;
    tick();
  endtask

  task automatic test_flush();
    int dc;
    // Ops presented while busy: NOPs pass, real ops stall and are not executed
    in_valid  = 1'b1;
    in_op     = 4'd1;
    in_rs_val = $urandom;
    in_rt_val = $urandom;
    tick();
    in_op = 4'd0;
    #1;
    n_checks++;
    if (out_stall !== 1'b0 || out_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL nop_while_busy: stall=%b busy=%b, want 0 1", out_stall, out_busy);
    end
    in_op = 4'd12;
    #1;
    n_checks++;
    if (out_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL op12_while_busy: stall=%b, want 0", out_stall);
    end
    in_op     = 4'd7;
    in_rs_val = ~m_hi;
    #1;
    n_checks++;
    if (out_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL mthi_while_busy_stall: stall=%b, want 1", out_stall);
    end
    tick();
    n_checks++;
    if (out_hi !== m_hi) begin
      n_fail++;
      $display("FAIL mthi_while_busy_exec: hi=%h, want %h", out_hi, m_hi);
    end
    in_valid = 1'b0;
    in_op    = 4'd0;
    repeat (9) tick();
    in_flush = 1'b1;
    tick();
    in_flush = 1'b0;
    n_checks++;
    if (out_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_iter: busy=%b after flush, want 0", out_busy);
    end
    dc = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_done) dc++;
      tick();
    end
    n_checks++;
    if (dc != 0 || out_hi !== m_hi || out_lo !== m_lo) begin
      n_fail++;
      $display("FAIL flush_iter_state: done_pulses=%0d hi=%h lo=%h, want 0 %h %h", dc, out_hi, out_lo, m_hi, m_lo);
    end
    // Flush landing on the sign-fix cycle
    in_valid  = 1'b1;
    in_op     = 4'd3;
    in_rs_val = $urandom;
    in_rt_val = 32'd3;
    tick();
    in_valid = 1'b0;
    in_op    = 4'd0;
    repeat (32) tick();
    in_flush = 1'b1;
    tick();
    in_flush = 1'b0;
    n_checks++;
    if (out_busy !== 1'b0 || out_done !== 1'b0 || out_hi !== m_hi || out_lo !== m_lo) begin
      n_fail++;
      $display("FAIL flush_fix: busy=%b done=%b hi=%h lo=%h, want 0 0 %h %h",
               out_busy, out_done, out_hi, out_lo, m_hi, m_lo);
    end
    // Flush wins over a valid op in IDLE
    in_valid  = 1'b1;
    in_flush  = 1'b1;
    in_op     = 4'd7;
    in_rs_val = ~m_hi;
    tick();
    in_op     = 4'd2;
    tick();
    in_valid = 1'b0;
    in_flush = 1'b0;
    in_op    = 4'd0;
    n_checks++;
    if (out_hi !== m_hi || out_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle: hi=%h busy=%b, want %h 0", out_hi, out_busy, m_hi);
    end
  endtask

  task automatic test_mid_reset();
    int dc;
    in_valid  = 1'b1;
    in_op     = 4'd2;
    in_rs_val = $urandom;
    in_rt_val = $urandom;
    tick();
    in_valid = 1'b0;
    in_op    = 4'd0;
    repeat (5) tick();
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (out_hi !== 32'd0 || out_lo !== 32'd0 || out_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: hi=%h lo=%h busy=%b, want 0 0 0", out_hi, out_lo, out_busy);
    end
    tick();
    reset_n = 1'b1;
    m_hi = '0;
    m_lo = '0;
    dc = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_done) dc++;
      tick();
    end
    n_checks++;
    if (dc != 0) begin
      n_fail++;
      $display("FAIL mid_reset_no_done: done_pulses=%0d, want 0", dc);
    end
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] rs, rt;
    logic [63:0] exp;
    int          bc;
    bit          gd;
    logic        dz, exp_dz;
    for (int n = 0; n < 40; n++) begin
      op = 4'($urandom_range(1, 4));
      rs = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 7))
        0:       rt = 32'd0;
        1:       rt = 32'($urandom_range(1, 15));
        2:       rt = 32'hFFFF_FFFF;
        default: rt = 32'($urandom);
      endcase
      exp    = ref_md(op, rs, rt);
      exp_dz = (op >= 4'd3) && (rt == 32'd0);
      issue_md(op, rs, rt, bc, gd, dz);
      n_checks++;
      if (!gd || dz !== exp_dz || out_hi !== exp[63:32] || out_lo !== exp[31:0]) begin
        n_fail++;
        $display("FAIL random_op%0d: op=%0d rs=%h rt=%h got done=%0d dz=%b hi=%h lo=%h, want dz=%b hi=%h lo=%h",
                 n, op, rs, rt, gd, dz, out_hi, out_lo, exp_dz, exp[63:32], exp[31:0]);
      end
      m_hi = exp[63:32];
      m_lo = exp[31:0];
    end
  endtask

  initial begin
    test_reset();
    test_mult_directed();
    test_div_directed();
    test_move();
    test_stall_mflo();
    test_flush();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
